// File: rtl/spi_i2c_pkg.sv
// Shared encodings for the SPI-to-I2C sequencer: command opcodes, mode bytes,
// FSM states and the I2C command payload.
package spi_i2c_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] MODE_I2C = 8'hC0;
    localparam logic [BYTE_W-1:0] MODE_OFF = 8'hC1;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_STOP  = 2'd3
    } cmd_op_e;

    typedef enum logic [3:0] {
        ST_OFF,
        ST_I2C_IDLE,
        ST_START,
        ST_ADDR,
        ST_WAIT_ADDR,
        ST_WR_WAIT,
        ST_WR_BYTE,
        ST_WAIT_WR,
        ST_RD_COUNT,
        ST_RD_BYTE,
        ST_WAIT_RD,
        ST_DRAIN,
        ST_STOP
    } state_e;

    typedef struct packed {
        cmd_op_e           op;
        logic [BYTE_W-1:0] wdata;
        logic              nack;
    } cmd_t;

endpackage

// File: rtl/spi_i2c_sequencer_if.sv
// Bus bundle between the sequencer and its SPI byte receiver, I2C byte engine
// and status LEDs.
interface spi_i2c_sequencer_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       cmd_nack;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       i2c_mode;
    logic       busy;
    logic       err_nack;
    logic       err_ovf;

    modport master (
        input  rx_valid, rx_data, cmd_ready, rsp_valid, rsp_rdata, rsp_nack,
        output tx_data, tx_load, cmd_valid, cmd_op, cmd_wdata, cmd_nack,
               i2c_mode, busy, err_nack, err_ovf
    );

    modport slave (
        output rx_valid, rx_data, cmd_ready, rsp_valid, rsp_rdata, rsp_nack,
        input  tx_data, tx_load, cmd_valid, cmd_op, cmd_wdata, cmd_nack,
               i2c_mode, busy, err_nack, err_ovf
    );

endinterface

// File: rtl/idle_timer.sv
// Inter-byte idle counter: runs while enabled, clears on demand and flags the
// last idle clock before the open transaction must be closed.
module idle_timer #(
    parameter int unsigned IDLE_TIMEOUT = 1024,
    parameter int unsigned TO_W         = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TO_W'(1);
        end
    end

    assign expire_c = enable && !clear && (count == TO_W'(IDLE_TIMEOUT - 1));

endmodule

// File: rtl/spi_i2c_sequencer.sv
// Turns the SPI byte stream (mode byte, address byte, data/count bytes) into
// START/WRITE/READ/STOP commands for the I2C engine and returns read bytes to SPI.
module spi_i2c_sequencer
    import spi_i2c_pkg::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 1024,
    parameter int unsigned TO_W         = 11
) (
    input  logic                clk,
    input  logic                rst,
    spi_i2c_sequencer_if.master bus
);

    state_e            state, state_nxt;
    cmd_t              cmd_q, cmd_nxt;
    logic              cmd_valid_q, cmd_valid_nxt;
    logic [BYTE_W-1:0] addr_q, addr_nxt;
    logic [BYTE_W-1:0] wbyte_q, wbyte_nxt;
    logic [BYTE_W-1:0] hold_q, hold_nxt;
    logic              hold_full_q, hold_full_nxt;
    logic [BYTE_W-1:0] rd_left_q, rd_left_nxt;
    logic [BYTE_W-1:0] tx_data_q, tx_data_nxt;
    logic              tx_load_q, tx_load_nxt;
    logic              i2c_mode_q, i2c_mode_nxt;
    logic              busy_q, busy_nxt;
    logic              err_nack_q, err_nack_nxt;
    logic              err_ovf_q, err_ovf_nxt;
    logic [BYTE_W-1:0] rd_count_c;
    logic              cmd_fire_c, timing_c, hold_en_c, tmr_clear_c, expire_c;

    assign cmd_fire_c  = cmd_valid_q && bus.cmd_ready;
    assign timing_c    = (state == ST_WR_WAIT) || (state == ST_RD_COUNT);
    assign tmr_clear_c = bus.rx_valid || !timing_c;
    assign hold_en_c   = (state == ST_START)   || (state == ST_ADDR) ||
                         (state == ST_WAIT_ADDR) || (state == ST_WR_BYTE) ||
                         (state == ST_WAIT_WR);

    idle_timer #(
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .TO_W         (TO_W)
    ) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear_c),
        .enable   (timing_c),
        .expire_c (expire_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_OFF;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            addr_q      <= '0;
            wbyte_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rd_left_q   <= '0;
            tx_data_q   <= '0;
            tx_load_q   <= 1'b0;
            i2c_mode_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_nack_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd_q       <= cmd_nxt;
            cmd_valid_q <= cmd_valid_nxt;
            addr_q      <= addr_nxt;
            wbyte_q     <= wbyte_nxt;
            hold_q      <= hold_nxt;
            hold_full_q <= hold_full_nxt;
            rd_left_q   <= rd_left_nxt;
            tx_data_q   <= tx_data_nxt;
            tx_load_q   <= tx_load_nxt;
            i2c_mode_q  <= i2c_mode_nxt;
            busy_q      <= busy_nxt;
            err_nack_q  <= err_nack_nxt;
            err_ovf_q   <= err_ovf_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cmd_nxt       = cmd_q;
        cmd_valid_nxt = cmd_valid_q;
        addr_nxt      = addr_q;
        wbyte_nxt     = wbyte_q;
        hold_nxt      = hold_q;
        hold_full_nxt = hold_full_q;
        rd_left_nxt   = rd_left_q;
        tx_data_nxt   = tx_data_q;
        tx_load_nxt   = 1'b0;
        err_nack_nxt  = err_nack_q;
        err_ovf_nxt   = err_ovf_q;
        rd_count_c    = '0;

        // Bytes arriving while a command is outstanding park in the one-byte slot.
        if (hold_en_c && bus.rx_valid) begin
            if (hold_full_q) begin
                err_ovf_nxt = 1'b1;
            end else begin
                hold_nxt      = bus.rx_data;
                hold_full_nxt = 1'b1;
            end
        end

        case (state)
            ST_OFF: begin
                if (bus.rx_valid && bus.rx_data == MODE_I2C) begin
                    state_nxt    = ST_I2C_IDLE;
                    err_nack_nxt = 1'b0;
                    err_ovf_nxt  = 1'b0;
                end
            end
            ST_I2C_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == MODE_I2C) begin
                        err_nack_nxt = 1'b0;
                        err_ovf_nxt  = 1'b0;
                    end else if (bus.rx_data == MODE_OFF) begin
                        state_nxt = ST_OFF;
                    end else begin
                        addr_nxt  = bus.rx_data;
                        state_nxt = ST_START;
                    end
                end
            end
            ST_START: begin
                if (cmd_fire_c) begin
                    cmd_valid_nxt = 1'b0;
                    state_nxt     = ST_ADDR;
                end else if (!cmd_valid_q) begin
                    cmd_valid_nxt = 1'b1;
                    cmd_nxt       = '{OP_START, 8'h00, 1'b0};
                end
            end
            ST_ADDR: begin
                if (cmd_fire_c) begin
                    cmd_valid_nxt = 1'b0;
                    state_nxt     = ST_WAIT_ADDR;
                end else if (!cmd_valid_q) begin
                    cmd_valid_nxt = 1'b1;
                    cmd_nxt       = '{OP_WRITE, addr_q, 1'b0};
                end
            end
            ST_WAIT_ADDR: begin
                if (bus.rsp_valid) begin
                    if (bus.rsp_nack) begin
                        err_nack_nxt = 1'b1;
                        state_nxt    = ST_DRAIN;
                    end else begin
                        state_nxt = addr_q[0] ? ST_RD_COUNT : ST_WR_WAIT;
                    end
                end
            end
            ST_WR_WAIT: begin
                // A held byte goes first; a byte arriving in the same cycle takes its slot.
                if (hold_full_q) begin
                    wbyte_nxt     = hold_q;
                    hold_nxt      = bus.rx_data;
                    hold_full_nxt = bus.rx_valid;
                    state_nxt     = ST_WR_BYTE;
                end else if (bus.rx_valid) begin
                    wbyte_nxt = bus.rx_data;
                    state_nxt = ST_WR_BYTE;
                end else if (expire_c) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_WR_BYTE: begin
                if (cmd_fire_c) begin
                    cmd_valid_nxt = 1'b0;
                    state_nxt     = ST_WAIT_WR;
                end else if (!cmd_valid_q) begin
                    cmd_valid_nxt = 1'b1;
                    cmd_nxt       = '{OP_WRITE, wbyte_q, 1'b0};
                end
            end
            ST_WAIT_WR: begin
                if (bus.rsp_valid) begin
                    if (bus.rsp_nack) begin
                        err_nack_nxt = 1'b1;
                        state_nxt    = ST_DRAIN;
                    end else begin
                        state_nxt = ST_WR_WAIT;
                    end
                end
            end
            ST_RD_COUNT: begin
                if (hold_full_q || bus.rx_valid) begin
                    rd_count_c    = hold_full_q ? hold_q : bus.rx_data;
                    hold_full_nxt = 1'b0;
                    if (rd_count_c == '0) begin
                        state_nxt = ST_STOP;
                    end else begin
                        rd_left_nxt = rd_count_c;
                        state_nxt   = ST_RD_BYTE;
                    end
                end else if (expire_c) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_RD_BYTE: begin
                if (cmd_fire_c) begin
                    cmd_valid_nxt = 1'b0;
                    state_nxt     = ST_WAIT_RD;
                end else if (!cmd_valid_q) begin
                    cmd_valid_nxt = 1'b1;
                    cmd_nxt       = '{OP_READ, 8'h00, (rd_left_q == 8'd1)};
                end
            end
            ST_WAIT_RD: begin
                if (bus.rsp_valid) begin
                    tx_data_nxt = bus.rsp_rdata;
                    tx_load_nxt = 1'b1;
                    rd_left_nxt = rd_left_q - 8'd1;
                    state_nxt   = (rd_left_q == 8'd1) ? ST_STOP : ST_RD_BYTE;
                end
            end
            ST_DRAIN: begin
                hold_full_nxt = 1'b0;
                state_nxt     = ST_STOP;
            end
            ST_STOP: begin
                if (cmd_fire_c) begin
                    cmd_valid_nxt = 1'b0;
                    state_nxt     = ST_I2C_IDLE;
                end else if (!cmd_valid_q) begin
                    cmd_valid_nxt = 1'b1;
                    cmd_nxt       = '{OP_STOP, 8'h00, 1'b0};
                end
            end
            default: begin
                state_nxt     = ST_OFF;
                cmd_valid_nxt = 1'b0;
            end
        endcase

        i2c_mode_nxt = (state_nxt != ST_OFF);
        busy_nxt     = (state_nxt != ST_OFF) && (state_nxt != ST_I2C_IDLE);
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_load   = tx_load_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_op    = cmd_q.op;
    assign bus.cmd_wdata = cmd_q.wdata;
    assign bus.cmd_nack  = cmd_q.nack;
    assign bus.i2c_mode  = i2c_mode_q;
    assign bus.busy      = busy_q;
    assign bus.err_nack  = err_nack_q;
    assign bus.err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_spi_i2c_sequencer.sv
// Directed bench for spi_i2c_sequencer with a small I2C engine responder that
// logs every accepted command and every byte returned to the SPI side.
module tb_spi_i2c_sequencer;
    import spi_i2c_pkg::*;

    localparam int unsigned IDLE_TIMEOUT = 1024;
    localparam int unsigned TO_W         = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_i2c_sequencer_if bus ();

    spi_i2c_sequencer #(
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .TO_W         (TO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Engine knobs written only by the stimulus process
    int rsp_delay = 3;
    int stall_len = 0;
    int stall_req = 0;
    int nack_req  = 0;

    logic [10:0] cmd_log[$];
    logic [7:0]  tx_log[$];
    logic [10:0] exp_q[$];

    function automatic logic [10:0] enc(cmd_op_e op, logic [7:0] wd, logic nk);
        return {nk, op, wd};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // I2C engine responder: acts on the falling edge, so the handshake it sees
    // completes on the following rising edge.
    int          stall_seen = 0;
    int          stall_cnt  = 0;
    int          nack_seen  = 0;
    bit          pend       = 1'b0;
    int          pend_cnt   = 0;
    bit          pend_rd    = 1'b0;
    bit          pend_nack  = 1'b0;
    logic [7:0]  rd_ctr     = 8'h00;

    always @(negedge clk) begin
        if (bus.tx_load) tx_log.push_back(bus.tx_data);
        if (rst) begin
            pend          = 1'b0;
            stall_cnt     = 0;
            stall_seen    = stall_req;
            bus.rsp_valid = 1'b0;
            bus.rsp_nack  = 1'b0;
            bus.rsp_rdata = 8'h00;
            bus.cmd_ready = 1'b1;
        end else begin
            bus.rsp_valid = 1'b0;
            if (stall_req != stall_seen) begin
                stall_seen = stall_req;
                stall_cnt  = stall_len;
            end
            if (pend) begin
                if (pend_cnt == 0) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_nack  = pend_nack;
                    bus.rsp_rdata = pend_rd ? rd_ctr : 8'h00;
                    if (pend_rd) rd_ctr = rd_ctr + 8'd1;
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (stall_cnt > 0) begin
                bus.cmd_ready = 1'b0;
                stall_cnt--;
            end else begin
                bus.cmd_ready = 1'b1;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                cmd_log.push_back(enc(cmd_op_e'(bus.cmd_op),
                                      (bus.cmd_op == 2'd1) ? bus.cmd_wdata : 8'h00,
                                      (bus.cmd_op == 2'd2) ? bus.cmd_nack : 1'b0));
                if (bus.cmd_op == 2'd1 || bus.cmd_op == 2'd2) begin
                    pend      = 1'b1;
                    pend_cnt  = rsp_delay;
                    pend_rd   = (bus.cmd_op == 2'd2);
                    pend_nack = (bus.cmd_op == 2'd1) && (nack_req != nack_seen);
                    if (pend_nack) nack_seen = nack_req;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_cmds(input string tag, input int base);
        check({tag, "_len"}, 32'(cmd_log.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < cmd_log.size())
                check($sformatf("%s_%0d", tag, i), 32'(cmd_log[base + i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got no summary expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int tbase;
        int n;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst          = 1'b1;
        idle(3);
        check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("rst_cmd",       32'({bus.cmd_op, bus.cmd_wdata, bus.cmd_nack}), 32'd0);
        check("rst_tx",        32'({bus.tx_load, bus.tx_data}), 32'd0);
        check("rst_mode_busy", 32'({bus.i2c_mode, bus.busy}), 32'd0);
        check("rst_errs",      32'({bus.err_nack, bus.err_ovf}), 32'd0);
        rst = 1'b0;
        tick();

        // Test 1: write transaction closed by the idle timeout
        base = cmd_log.size();
        send(8'hC0);
        idle(50);
        check("t1_mode", 32'(bus.i2c_mode), 32'd1);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);
        send(8'h70);
        idle(50);
        send(8'hAA);
        idle(50);
        send(8'hCC);
        idle(500);
        check("t1_busy_open", 32'(bus.busy), 32'd1);
        wait_done("t1_stop", 700, n);
        check("t1_timeout_window", 32'((n + 500 >= 1024) && (n + 500 <= 1060)), 32'd1);
        exp_q.delete();
        exp_q.push_back(enc(OP_START, 8'h00, 1'b0));
        exp_q.push_back(enc(OP_WRITE, 8'h70, 1'b0));
        exp_q.push_back(enc(OP_WRITE, 8'hAA, 1'b0));
        exp_q.push_back(enc(OP_WRITE, 8'hCC, 1'b0));
        exp_q.push_back(enc(OP_STOP, 8'h00, 1'b0));
        check_cmds("t1_cmd", base);

        // Test 2: 37-byte read without resending the mode byte, plus a dummy byte
        base  = cmd_log.size();
        tbase = tx_log.size();
        send(8'h71);
        idle(50);
        send(8'h25);
        idle(10);
        send(8'h55);
        wait_done("t2_stop", 2000, n);
        exp_q.delete();
        exp_q.push_back(enc(OP_START, 8'h00, 1'b0));
        exp_q.push_back(enc(OP_WRITE, 8'h71, 1'b0));
        for (int i = 0; i < 36; i++) exp_q.push_back(enc(OP_READ, 8'h00, 1'b0));
        exp_q.push_back(enc(OP_READ, 8'h00, 1'b1));
        exp_q.push_back(enc(OP_STOP, 8'h00, 1'b0));
        check_cmds("t2_cmd", base);
        check("t2_tx_count", 32'(tx_log.size() - tbase), 32'd37);
        for (int i = 0; i < 37; i++) begin
            if (tbase + i < tx_log.size())
                check($sformatf("t2_tx_%0d", i), 32'(tx_log[tbase + i]), 32'(i));
        end
        check("t2_errs", 32'({bus.err_nack, bus.err_ovf}), 32'd0);
        check("t2_mode", 32'(bus.i2c_mode), 32'd1);

        // Test 3: address NACK, pending data byte must be discarded
        rsp_delay = 20;
        nack_req++;
        base = cmd_log.size();
        send(8'hC0);
        idle(10);
        send(8'h70);
        idle(5);
        send(8'hAA);
        wait_done("t3_stop", 300, n);
        check("t3_err_nack", 32'(bus.err_nack), 32'd1);
        idle(30);
        check("t3_no_retry", 32'(bus.busy), 32'd0);
        exp_q.delete();
        exp_q.push_back(enc(OP_START, 8'h00, 1'b0));
        exp_q.push_back(enc(OP_WRITE, 8'h70, 1'b0));
        exp_q.push_back(enc(OP_STOP, 8'h00, 1'b0));
        check_cmds("t3_cmd", base);
        rsp_delay = 3;
        send(8'hC0);
        idle(5);
        check("t3_nack_cleared", 32'(bus.err_nack), 32'd0);

        // Test 4: three back-to-back data bytes while the engine stalls
        base = cmd_log.size();
        send(8'h70);
        idle(30);
        stall_len = 200;
        stall_req++;
        idle(2);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        check("t4_ovf_set", 32'(bus.err_ovf), 32'd1);
        wait_done("t4_stop", 3000, n);
        check("t4_ovf_sticky", 32'(bus.err_ovf), 32'd1);
        check("t4_nack_clear", 32'(bus.err_nack), 32'd0);
        exp_q.delete();
        exp_q.push_back(enc(OP_START, 8'h00, 1'b0));
        exp_q.push_back(enc(OP_WRITE, 8'h70, 1'b0));
        exp_q.push_back(enc(OP_WRITE, 8'h11, 1'b0));
        exp_q.push_back(enc(OP_WRITE, 8'h22, 1'b0));
        exp_q.push_back(enc(OP_STOP, 8'h00, 1'b0));
        check_cmds("t4_cmd", base);

        // Test 5: reset while a READ response is outstanding
        base  = cmd_log.size();
        tbase = tx_log.size();
        send(8'h71);
        idle(30);
        rsp_delay = 40;
        send(8'h03);
        idle(10);
        check("t5_pre_busy", 32'(bus.busy), 32'd1);
        check("t5_pre_ovf", 32'(bus.err_ovf), 32'd1);
        check("t5_pre_cmds", 32'(cmd_log.size() - base), 32'd3);
        rst = 1'b1;
        tick();
        check("t5_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_mode", 32'(bus.i2c_mode), 32'd0);
        check("t5_errs", 32'({bus.err_nack, bus.err_ovf}), 32'd0);
        check("t5_tx_load", 32'(bus.tx_load), 32'd0);
        rst       = 1'b0;
        rsp_delay = 3;
        idle(60);
        check("t5_no_tx", 32'(tx_log.size() - tbase), 32'd0);
        check("t5_no_stop", 32'(cmd_log.size() - base), 32'd3);

        // Test 6: bytes ignored while OFF, then a zero-length read
        base = cmd_log.size();
        send(8'hC1);
        idle(5);
        check("t6_off_mode", 32'(bus.i2c_mode), 32'd0);
        send(8'h70);
        idle(20);
        check("t6_off_busy", 32'(bus.busy), 32'd0);
        send(8'h71);
        idle(5);
        send(8'h00);
        idle(20);
        check("t6_off_cmds", 32'(cmd_log.size() - base), 32'd0);
        check("t6_still_off", 32'(bus.i2c_mode), 32'd0);
        send(8'hC0);
        idle(5);
        check("t6_on_mode", 32'(bus.i2c_mode), 32'd1);
        send(8'h71);
        idle(30);
        send(8'h00);
        wait_done("t6_stop", 200, n);
        exp_q.delete();
        exp_q.push_back(enc(OP_START, 8'h00, 1'b0));
        exp_q.push_back(enc(OP_WRITE, 8'h71, 1'b0));
        exp_q.push_back(enc(OP_STOP, 8'h00, 1'b0));
        check_cmds("t6_cmd", base);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_i2c_sequencer.md
Name: spi_i2c_sequencer

Overview:
Controller between the SPI slave byte receiver and the I2C master byte engine on the audio shield. Interprets the incoming SPI byte stream (mode byte, I2C address byte, data or count bytes) and issues START/WRITE/READ/STOP commands to the I2C engine. Returns read bytes to the SPI transmit path. Ends a transaction with STOP after an inter-byte idle timeout, because SPI CS is deasserted between individual bytes.

Parameters:
IDLE_TIMEOUT, 1024, clocks with no new rx byte before an open I2C transaction is closed with STOP
TO_W, 11, width of the timeout counter; must hold IDLE_TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_valid  in  1  one-cycle strobe: rx_data holds a complete SPI byte
rx_data  in  8  received SPI byte
tx_data  out  8  byte presented to the SPI slave for the next shift-out
tx_load  out  1  one-cycle strobe: tx_data updated
cmd_valid  out  1  command to I2C engine valid
cmd_ready  in  1  I2C engine accepts the command when cmd_valid && cmd_ready
cmd_op  out  2  0=START, 1=WRITE, 2=READ, 3=STOP
cmd_wdata  out  8  WRITE byte
cmd_nack  out  1  READ: master sends NACK (last byte)
rsp_valid  in  1  one-cycle strobe: WRITE or READ completed
rsp_rdata  in  8  READ result
rsp_nack  in  1  WRITE: slave NACKed
i2c_mode  out  1  I2C mode active (LED)
busy  out  1  I2C transaction open
err_nack  out  1  sticky; cleared by mode byte 0xC0
err_ovf  out  1  sticky; cleared by mode byte 0xC0

Behaviour:
- Reset values: all outputs 0; state OFF; holding register empty; timeout counter 0.
- Mode bytes are recognised only in OFF or I2C_IDLE. 0xC0 enters I2C mode and clears both error flags. 0xC1 leaves I2C mode (goes to OFF). Other bytes in OFF are dropped. I2C addresses 0x60/0x61 are reserved.
- Mode is sticky: consecutive transactions do not resend 0xC0.
- States: OFF, I2C_IDLE, START, ADDR, WAIT_ADDR, WR_WAIT, WR_BYTE, WAIT_WR, RD_COUNT, RD_BYTE, WAIT_RD, DRAIN, STOP.
- I2C_IDLE: a non-mode byte latches the address byte A and moves to START.
- START: issue START. Then ADDR: issue WRITE with A. Then WAIT_ADDR waits for rsp_valid.
  - rsp_nack=1: set err_nack, go to DRAIN.
  - A[0]=0: go to WR_WAIT.
  - A[0]=1: go to RD_COUNT.
- WR_WAIT: each rx byte goes to WR_BYTE (WRITE), then WAIT_WR. NACK sets err_nack and goes to DRAIN; ACK returns to WR_WAIT.
- RD_COUNT: the next rx byte is the read count N.
  - N=0: go to STOP.
  - Otherwise issue N READs. cmd_nack=1 only on the N-th READ.
  - Each rsp_valid drives tx_data<=rsp_rdata and pulses tx_load for 1 cycle.
  - After the N-th response, go to STOP.
  - rx bytes arriving during reads are dummies and are discarded without error.
- DRAIN: discard rx bytes; go to STOP immediately.
- STOP: issue STOP; on handshake go to I2C_IDLE.
- cmd handshake: cmd_valid is held with stable cmd_op/cmd_wdata/cmd_nack until cmd_ready. cmd_valid deasserts the cycle after acceptance. Commands are never issued back-to-back without the response for WRITE/READ.
- Holding register: one byte.
  - An rx byte that arrives while WR_BYTE/WAIT_WR is pending is held.
  - A second byte arriving while the register is full is dropped and sets err_ovf.
  - rx byte and release in the same cycle: the new byte is held, no error.
- Timeout counter:
  - Counts clocks in WR_WAIT and RD_COUNT. Reset to 0 by rx_valid.
  - Reaching IDLE_TIMEOUT-1 goes to STOP.
  - It does not run in OFF, I2C_IDLE, or while waiting on cmd_ready/rsp_valid.
- busy=1 in every state except OFF and I2C_IDLE.
- rst mid-transaction: next cycle state is OFF and cmd_valid=0. No STOP is issued; the I2C engine is reset by the same rst.

Decomposition:
- Shared package (spi_i2c_pkg): cmd_op encodings, mode bytes MODE_I2C=8'hC0 and MODE_OFF=8'hC1, state enumeration.
- Sub-module idle_timer (load/clear, enable, expire pulse) holds the timeout counter.
- The FSM and holding register stay in spi_i2c_sequencer.

Test Plan:
1. Bytes C0,70,AA,CC with 50-clock gaps, engine ACKs all. Expected: i2c_mode=1; commands START, WRITE 70, WRITE AA, WRITE CC; after 1024 idle clocks STOP; busy falls.
2. After test 1, with no mode byte, send 71,25; engine returns bytes 00..24. Expected: START, WRITE 71, then 37 READs, cmd_nack only on the 37th; 37 tx_load pulses with tx_data 00..24; then STOP.
3. C0,70,AA with the engine NACKing the address. Expected: err_nack=1; STOP follows; AA is not written. A subsequent C0 clears err_nack.
4. Address 70, then three data bytes back-to-back while cmd_ready is held low for 200 clocks. Expected: the first is sent, the second is held, the third is dropped; err_ovf=1; writes are exactly the first two bytes.
5. Assert rst during WAIT_RD. Expected: next cycle cmd_valid=0, busy=0, i2c_mode=0, all errors 0, tx_load=0.
6. Send C1, then 70. Expected: i2c_mode=0 and no commands issued. Then send 71,00. Expected: nothing issued (still OFF). After C0, send 71,00. Expected: START, WRITE 71, STOP, with no READ.
